// File: rtl/majority_pkg.sv
// Shared types and helpers for the N-channel majority voter and its per-channel health trackers.
package majority_pkg;

    localparam int MAX_CH   = 7;
    localparam int POP_W    = $clog2(MAX_CH + 1);
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        HEALTHY = 2'd0,
        SUSPECT = 2'd1,
        FAILED  = 2'd2
    } ch_state_t;

    function automatic logic [POP_W-1:0] popcount_n(input logic [MAX_CH-1:0] vec);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            cnt = cnt + POP_W'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/majority_voter_n_ch_health_fsm.sv
// Per-channel health tracker: counts consecutive miscompares and latches FAILED until cleared.
module ch_health_fsm
    import majority_pkg::*;
#(
    parameter int FAIL_THRESH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      sample_en,
    input  logic      miscompare,
    input  logic      clear,
    output logic      failed,
    output ch_state_t state
);

    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_next;
    ch_state_t           state_next;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HEALTHY;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        state_next  = state;
        streak_next = streak;
        if (clear) begin
            state_next  = HEALTHY;
            streak_next = '0;
        end else if (sample_en) begin
            unique case (state)
                HEALTHY: begin
                    if (miscompare) begin
                        state_next  = SUSPECT;
                        streak_next = STREAK_W'(1);
                    end
                end
                SUSPECT: begin
                    if (miscompare) begin
                        streak_next = streak + STREAK_W'(1);
                        if (streak_next == STREAK_W'(FAIL_THRESH)) begin
                            state_next = FAILED;
                        end
                    end else begin
                        state_next  = HEALTHY;
                        streak_next = '0;
                    end
                end
                FAILED: begin
                    // Sticky until clear.
                end
                default: begin
                    state_next  = HEALTHY;
                    streak_next = '0;
                end
            endcase
        end
    end

    assign failed = (state == FAILED);

endmodule

// File: rtl/majority_voter_n.sv
// N-channel bitwise majority voter with registered outputs, miscompare counting and channel eviction.
module majority_voter_n
    import majority_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int WIDTH       = 8,
    parameter int FAIL_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       clear_fail,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [N_CH-1:0]       mismatch,
    output logic                  vote_tie,
    output logic                  all_failed,
    output logic [N_CH-1:0]       ch_failed,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int PC_W = $clog2(N_CH + 1);

    ch_state_t         ch_state [N_CH];
    logic [N_CH-1:0]   active;
    logic [N_CH-1:0]   mis_c;
    logic [WIDTH-1:0]  voted;
    logic              tie_c;
    logic [PC_W-1:0]   n_active;
    logic [PC_W-1:0]   ones;
    logic [PC_W-1:0]   inc;
    logic [MAX_CH-1:0] bit_vec;
    logic [MAX_CH-1:0] ext_active;
    logic [MAX_CH-1:0] ext_counted;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  cnt_next;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_health_fsm #(
            .FAIL_THRESH(FAIL_THRESH)
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .sample_en (in_valid),
            .miscompare(mis_c[i]),
            .clear     (clear_fail[i]),
            .failed    (ch_failed[i]),
            .state     (ch_state[i])
        );
        assign active[i] = (ch_state[i] != FAILED);
    end

    // Vote over the channels that were healthy before this sample; a bit is 1 only on a strict majority.
    always_comb begin
        voted       = '0;
        tie_c       = 1'b0;
        mis_c       = '0;
        ones        = '0;
        bit_vec     = '0;
        ext_active  = '0;
        ext_counted = '0;
        ext_active[N_CH-1:0] = active;
        n_active = PC_W'(popcount_n(ext_active));
        for (int b = 0; b < WIDTH; b++) begin
            bit_vec = '0;
            for (int i = 0; i < N_CH; i++) begin
                bit_vec[i] = active[i] & in_data[i*WIDTH + b];
            end
            ones = PC_W'(popcount_n(bit_vec));
            if ({ones, 1'b0} > {1'b0, n_active}) begin
                voted[b] = 1'b1;
            end else if ((n_active != '0) && ({ones, 1'b0} == {1'b0, n_active})) begin
                tie_c = 1'b1;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            mis_c[i] = (in_data[i*WIDTH +: WIDTH] != voted);
        end
        ext_counted[N_CH-1:0] = mis_c & active;
        inc      = PC_W'(popcount_n(ext_counted));
        cnt_sum  = {1'b0, err_cnt} + (CNT_W+1)'(inc);
        cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            mismatch   <= '0;
            vote_tie   <= 1'b0;
            all_failed <= 1'b0;
            err_cnt    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data   <= voted;
                mismatch   <= mis_c;
                vote_tie   <= tie_c;
                all_failed <= (n_active == '0);
                err_cnt    <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_majority_voter_n.sv
// Self-checking bench for majority_voter_n: directed table, corner sequences and a randomized model comparison.
module tb_majority_voter_n;

    localparam int N_CH        = 3;
    localparam int WIDTH       = 8;
    localparam int FAIL_THRESH = 4;
    localparam int CNT_W       = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       clear_fail;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [N_CH-1:0]       mismatch;
    logic                  vote_tie;
    logic                  all_failed;
    logic [N_CH-1:0]       ch_failed;
    logic [CNT_W-1:0]      err_cnt;

    int total = 0;
    int bad   = 0;

    majority_voter_n #(
        .N_CH(N_CH), .WIDTH(WIDTH), .FAIL_THRESH(FAIL_THRESH), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear_fail(clear_fail),
        .out_valid (out_valid),
        .out_data  (out_data),
        .mismatch  (mismatch),
        .vote_tie  (vote_tie),
        .all_failed(all_failed),
        .ch_failed (ch_failed),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: plain integers and flags, updated once per clock from the rules.
    bit       m_failed [N_CH];
    int       m_streak [N_CH];
    bit       m_ov;
    bit [7:0] m_data;
    bit [2:0] m_mis;
    bit       m_tie;
    bit       m_all;
    int       m_cnt;

    typedef struct {
        logic        v;
        logic [23:0] d;
        logic [2:0]  c;
        logic        e_ov;
        logic [7:0]  e_data;
        logic [2:0]  e_mis;
        logic        e_tie;
        logic        e_all;
        logic [2:0]  e_failed;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic [7:0] d, input logic [2:0] mis,
                              input logic tie, input logic all, input logic [2:0] fl, input logic [15:0] cnt);
        check({tag, ".out_valid"},  64'(out_valid),  64'(ov));
        check({tag, ".out_data"},   64'(out_data),   64'(d));
        check({tag, ".mismatch"},   64'(mismatch),   64'(mis));
        check({tag, ".vote_tie"},   64'(vote_tie),   64'(tie));
        check({tag, ".all_failed"}, 64'(all_failed), 64'(all));
        check({tag, ".ch_failed"},  64'(ch_failed),  64'(fl));
        check({tag, ".err_cnt"},    64'(err_cnt),    64'(cnt));
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_failed[i] = 1'b0;
            m_streak[i] = 0;
        end
        m_ov = 0; m_data = 0; m_mis = 0; m_tie = 0; m_all = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic v, input logic [23:0] d, input logic [2:0] c);
        int       a;
        int       ones;
        int       k;
        bit [7:0] vote;
        bit       tie;
        bit [2:0] mis;
        mis  = '0;
        m_ov = v;
        if (v) begin
            a = 0;
            for (int i = 0; i < N_CH; i++) if (!m_failed[i]) a++;
            vote = '0;
            tie  = 1'b0;
            for (int b = 0; b < WIDTH; b++) begin
                ones = 0;
                for (int i = 0; i < N_CH; i++) if (!m_failed[i] && d[i*WIDTH + b]) ones++;
                if (2 * ones > a) vote[b] = 1'b1;
                else if (a > 0 && 2 * ones == a) tie = 1'b1;
            end
            k = 0;
            for (int i = 0; i < N_CH; i++) begin
                mis[i] = (d[i*WIDTH +: WIDTH] != vote);
                if (mis[i] && !m_failed[i]) k++;
            end
            m_cnt  = (m_cnt + k > CNT_MAX) ? CNT_MAX : m_cnt + k;
            m_data = vote;
            m_mis  = mis;
            m_tie  = tie;
            m_all  = (a == 0);
        end
        for (int i = 0; i < N_CH; i++) begin
            if (c[i]) begin
                m_streak[i] = 0;
                m_failed[i] = 1'b0;
            end else if (v && !m_failed[i]) begin
                if (mis[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] >= FAIL_THRESH) m_failed[i] = 1'b1;
                end else begin
                    m_streak[i] = 0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge) and sample #1 after the next edge.
    task automatic apply(input logic v, input logic [23:0] d, input logic [2:0] c);
        in_valid   = v;
        in_data    = d;
        clear_fail = c;
        model_step(v, d, c);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [23:0] d, input logic [2:0] c,
                                input logic ov, input logic [7:0] ed, input logic [2:0] em,
                                input logic et, input logic ea, input logic [2:0] ef, input logic [15:0] ec);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.e_ov = ov; r.e_data = ed; r.e_mis = em;
        r.e_tie = et; r.e_all = ea; r.e_failed = ef; r.e_cnt = ec;
        return r;
    endfunction

    initial begin
        logic [2:0]  fl_exp;
        logic [7:0]  base;
        logic [23:0] rd;
        logic [2:0]  rc;

        // Directed vectors; data is packed {ch2, ch1, ch0}.
        tbl.push_back(mk(1, 24'hA5A5A5, 3'b000, 1, 8'hA5, 3'b000, 0, 0, 3'b000, 16'd0));
        tbl.push_back(mk(1, 24'hF03C0F, 3'b000, 1, 8'h3C, 3'b101, 0, 0, 3'b000, 16'd2));
        tbl.push_back(mk(1, 24'h555555, 3'b000, 1, 8'h55, 3'b000, 0, 0, 3'b000, 16'd2));
        tbl.push_back(mk(1, 24'h11EE11, 3'b000, 1, 8'h11, 3'b010, 0, 0, 3'b000, 16'd3));
        tbl.push_back(mk(0, 24'h000000, 3'b000, 0, 8'h11, 3'b010, 0, 0, 3'b000, 16'd3));
        tbl.push_back(mk(1, 24'h11EE11, 3'b000, 1, 8'h11, 3'b010, 0, 0, 3'b000, 16'd4));
        tbl.push_back(mk(0, 24'hFFFFFF, 3'b000, 0, 8'h11, 3'b010, 0, 0, 3'b000, 16'd4));
        tbl.push_back(mk(1, 24'h11EE11, 3'b000, 1, 8'h11, 3'b010, 0, 0, 3'b000, 16'd5));
        tbl.push_back(mk(0, 24'h123456, 3'b000, 0, 8'h11, 3'b010, 0, 0, 3'b000, 16'd5));
        tbl.push_back(mk(1, 24'h11EE11, 3'b000, 1, 8'h11, 3'b010, 0, 0, 3'b010, 16'd6));
        tbl.push_back(mk(1, 24'h34FF12, 3'b000, 1, 8'h10, 3'b111, 1, 0, 3'b010, 16'd8));
        tbl.push_back(mk(1, 24'h770077, 3'b000, 1, 8'h77, 3'b010, 0, 0, 3'b010, 16'd8));
        tbl.push_back(mk(0, 24'h000000, 3'b010, 0, 8'h77, 3'b010, 0, 0, 3'b000, 16'd8));
        tbl.push_back(mk(1, 24'hA55A5A, 3'b000, 1, 8'h5A, 3'b100, 0, 0, 3'b000, 16'd9));
        tbl.push_back(mk(1, 24'hA55A5A, 3'b000, 1, 8'h5A, 3'b100, 0, 0, 3'b000, 16'd10));
        tbl.push_back(mk(1, 24'hA55A5A, 3'b000, 1, 8'h5A, 3'b100, 0, 0, 3'b000, 16'd11));
        tbl.push_back(mk(1, 24'h5A5A5A, 3'b000, 1, 8'h5A, 3'b000, 0, 0, 3'b000, 16'd11));
        tbl.push_back(mk(1, 24'hA55A5A, 3'b000, 1, 8'h5A, 3'b100, 0, 0, 3'b000, 16'd12));
        tbl.push_back(mk(1, 24'hA55A5A, 3'b000, 1, 8'h5A, 3'b100, 0, 0, 3'b000, 16'd13));
        tbl.push_back(mk(1, 24'hA55A5A, 3'b000, 1, 8'h5A, 3'b100, 0, 0, 3'b000, 16'd14));
        tbl.push_back(mk(1, 24'h5A5A5A, 3'b000, 1, 8'h5A, 3'b000, 0, 0, 3'b000, 16'd14));
        tbl.push_back(mk(1, 24'h33CC33, 3'b000, 1, 8'h33, 3'b010, 0, 0, 3'b000, 16'd15));
        tbl.push_back(mk(1, 24'h33CC33, 3'b000, 1, 8'h33, 3'b010, 0, 0, 3'b000, 16'd16));
        tbl.push_back(mk(1, 24'h33CC33, 3'b000, 1, 8'h33, 3'b010, 0, 0, 3'b000, 16'd17));
        tbl.push_back(mk(1, 24'h33CC33, 3'b010, 1, 8'h33, 3'b010, 0, 0, 3'b000, 16'd18));

        // Reset held with random inputs: every output must stay 0.
        model_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        clear_fail = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'($urandom);
            in_data    = 24'($urandom);
            clear_fail = 3'($urandom);
            @(posedge clk);
            #1;
            check_outs($sformatf("reset_hold%0d", i), 0, 8'h00, 3'b000, 0, 0, 3'b000, 16'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].c);
            check_outs($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_data, tbl[i].e_mis,
                       tbl[i].e_tie, tbl[i].e_all, tbl[i].e_failed, tbl[i].e_cnt);
        end

        // Evict every channel: ch1 first, then ch0 and ch2 disagree on tied bits.
        for (int i = 0; i < 4; i++) apply(1, 24'h33CC33, 3'b000);
        check_outs("evict_ch1", 1, 8'h33, 3'b010, 0, 0, 3'b010, 16'd22);
        for (int i = 0; i < 4; i++) begin
            apply(1, 24'h02CC01, 3'b000);
            fl_exp = (i == 3) ? 3'b111 : 3'b010;
            check_outs($sformatf("evict_pair%0d", i), 1, 8'h00, 3'b111, 1, 0, fl_exp, 16'(24 + 2 * i));
        end
        apply(1, 24'hFFFFFF, 3'b000);
        check_outs("all_failed", 1, 8'h00, 3'b111, 0, 1, 3'b111, 16'd30);
        apply(0, 24'h000000, 3'b000);
        check_outs("all_failed_hold", 0, 8'h00, 3'b111, 0, 1, 3'b111, 16'd30);

        // Drive err_cnt to saturation with all three channels disagreeing and kept healthy by clear.
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < CNT_MAX / 3; i++) apply(1, 24'h040201, 3'b111);
        check_outs("saturate_reach", 1, 8'h00, 3'b111, 0, 0, 3'b000, 16'hFFFF);
        for (int i = 0; i < 3; i++) apply(1, 24'h040201, 3'b111);
        check_outs("saturate_hold", 1, 8'h00, 3'b111, 0, 0, 3'b000, 16'hFFFF);

        // Mid-stream asynchronous reset: outputs clear without waiting for a clock edge.
        in_valid   = 1'b1;
        in_data    = 24'h040201;
        clear_fail = 3'b000;
        rst_n      = 1'b0;
        model_reset();
        #1;
        check_outs("async_reset", 0, 8'h00, 3'b000, 0, 0, 3'b000, 16'd0);
        @(posedge clk);
        #1;
        check_outs("async_reset_held", 0, 8'h00, 3'b000, 0, 0, 3'b000, 16'd0);
        rst_n = 1'b1;

        // Randomized traffic compared against the reference model.
        for (int n = 0; n < 400; n++) begin
            base = 8'($urandom);
            for (int i = 0; i < N_CH; i++) begin
                rd[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : base;
                rc[i] = ($urandom_range(0, 15) == 0);
            end
            apply($urandom_range(0, 3) != 0, rd, rc);
            for (int i = 0; i < N_CH; i++) fl_exp[i] = m_failed[i];
            check_outs($sformatf("rand%0d", n), m_ov, m_data, m_mis, m_tie, m_all, fl_exp, 16'(m_cnt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/majority_voter_n.md
Name: majority_voter_n

Overview:
Parametrised N-channel, W-bit bitwise majority voter with a registered output stage and per-channel fault tracking. Each channel that keeps disagreeing with the voted word is marked failed and removed from later votes until software clears it. The block sits between redundant datapath replicas (TMR/NMR) and downstream logic. It generalises the 3-input, 1-bit combinational majority gate.

Parameters:
N_CH, 3, number of redundant channels; legal range 3..7.
WIDTH, 8, bits per channel word.
FAIL_THRESH, 4, consecutive miscompare samples that mark a channel FAILED; legal range 2..15.
CNT_W, 16, width of the saturating total-miscompare counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is a sample this cycle
in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
clear_fail  input  N_CH  per-channel request to return a channel to HEALTHY
out_valid  output  1  out_data and flags are valid
out_data  output  WIDTH  voted word
mismatch  output  N_CH  channel i differed from the voted word in this sample
vote_tie  output  1  at least one bit was tied among active channels (tied bits resolve to 0)
all_failed  output  1  no active channels remained; out_data is 0
ch_failed  output  N_CH  per-channel FAILED state
err_cnt  output  CNT_W  total channel-miscompares, saturating at all-ones

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n=0, every output is 0 and every channel FSM is HEALTHY with streak=0.
- Active set: active[i] = ~ch_failed[i], using the registered state from before the current sample.
- Vote (combinational, then registered): for each bit, ones = count of active channels with the bit set, A = number of active channels. The bit is 1 iff 2*ones > A. A tie (2*ones == A) resolves to 0 and sets vote_tie. If A == 0, out_data = 0 and all_failed = 1.
- Latency: exactly 1 cycle. out_valid(t+1) = in_valid(t). out_data, mismatch, vote_tie and all_failed update only on in_valid cycles and hold otherwise.
- mismatch[i] = (channel i word != voted word). It is computed for all channels, failed ones included, for monitoring.
- err_cnt increments by popcount(mismatch & active) per valid sample and saturates at all-ones.
- Per-channel FSM, advancing only on in_valid cycles:
  - HEALTHY (streak=0): on miscompare, go to SUSPECT with streak=1.
  - SUSPECT: on miscompare, streak+1; when streak reaches FAIL_THRESH, go to FAILED. On a matching sample, go to HEALTHY with streak=0.
  - FAILED: sticky. Miscompares are ignored.
- Cycles with in_valid=0 do not change streaks.
- clear_fail[i]: in any cycle, valid or not, forces HEALTHY with streak=0. It takes priority over a simultaneous transition to FAILED or a streak increment in that cycle.
- ch_failed is registered and is first used in the vote of the next sample.
- Reset asserted mid-stream aborts everything immediately, with no partial output.
- All arithmetic is unsigned. The popcount width is clog2(N_CH+1).

Decomposition:
- Shared package majority_pkg holds:
  - the channel-state enum (HEALTHY, SUSPECT, FAILED);
  - the function popcount_n;
  - the constant MAX_CH=7.
- Sub-module ch_health_fsm: one instance per channel, with inputs sample_en, miscompare and clear, and outputs failed and state.
- The voting datapath stays in the top module.

Test Plan (N_CH=3, WIDTH=8, FAIL_THRESH=4):
1. Hold rst_n=0 with random inputs -> all outputs 0. Release, then send all channels 0xA5 with in_valid=1 -> next cycle out_valid=1, out_data=0xA5, mismatch=000, err_cnt=0.
2. Send ch0=0x0F, ch1=0x3C, ch2=0xF0 -> out_data=0x3C, mismatch=101, vote_tie=0, err_cnt=2.
3. Corrupt ch1 for 4 valid samples, with in_valid=0 gaps between them -> ch_failed=010 after the 4th sample. Then send ch0=0x12, ch1=0xFF, ch2=0x34 -> out_data=0x10, vote_tie=1, mismatch=111, and err_cnt counts only ch0 and ch2.
4. Corrupt ch2 for 3 samples, then one matching sample, then 3 more corrupt samples -> ch_failed stays 000.
5. Assert clear_fail[1] in the same cycle as ch1's 4th miscompare -> ch_failed[1]=0. Fail all three channels -> next sample gives all_failed=1, out_data=0x00.
6. Pulse rst_n low mid-stream while err_cnt=0xFFFF is saturated -> immediate zeroing of all outputs and state. Separately, confirm saturation holds at 0xFFFF under continued miscompares.
